// File: rtl/fpu_pkg.sv
// Shared FPU definitions: tag width, itof writeback entry layout and leading-one helper.
package fpu_pkg;

    localparam int unsigned TAG_W = 6;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             inexact;
    } itof_wb_entry_t;

    // Index of the most significant set bit; 0 for a zero operand.
    function automatic logic [4:0] lzc32(input logic [31:0] a);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) pos = 5'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/fpu_fifo.sv
// Generic DEPTH x WIDTH FIFO with wrap-bit pointers; ready depends on registered state only.
module fpu_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty      = (wptr_q == rptr_q);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop_ready && !empty;
    assign pop_data   = mem_q[rptr_q[AW-1:0]];
    assign count      = wptr_q - rptr_q;

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= push_data;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/itof_wb_queue.sv
// itof result queue ahead of FPU writeback. Optional per-entry inexact flag
// is built when ITOF_INEXACT_EN is defined.
module itof_wb_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = fpu_pkg::TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_int,
    input  logic [31:0]            in_y,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_y,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_inexact,
    output logic [$clog2(DEPTH):0] count
);

`ifdef ITOF_INEXACT_EN
    localparam int unsigned W = 32 + TAG_W + 1;

    // Inexact when |in_int| has set bits below the 24-bit significand window.
    function automatic logic calc_inexact(input logic [31:0] v);
        logic [31:0] a;
        logic [31:0] mask;
        logic [4:0]  p;
        a    = v[31] ? (~v + 32'd1) : v;
        p    = lzc32(a);
        mask = (p > 5'd23) ? ((32'd1 << (p - 5'd23)) - 32'd1) : 32'd0;
        return |(a & mask);
    endfunction

    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    assign in_data = {in_y, in_tag, calc_inexact(in_int)};
    assign {out_y, out_tag, out_inexact} = out_data;
`else
    localparam int unsigned W = 32 + TAG_W;

    logic [W-1:0] in_data;
    logic [W-1:0] out_data;
    logic         unused_int;

    assign unused_int  = ^in_int;
    assign in_data     = {in_y, in_tag};
    assign {out_y, out_tag} = out_data;
    assign out_inexact = 1'b0;
`endif

    fpu_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push_valid(in_valid),
        .push_ready(in_ready),
        .push_data (in_data),
        .pop_valid (out_valid),
        .pop_ready (out_ready),
        .pop_data  (out_data),
        .count     (count)
    );

endmodule
